// File: rtl/hazard_flow_controller.sv
// Pipeline hazard/flow controller: arbitrates dmem freeze, EX redirect, load-use
// and imem wait into fetch/decode/execute control, with stall and redirect counters.
module hazard_flow_controller #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   input  logic             perf_clear,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IF_ID_Write,
   output logic             Instr_Flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_t           state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic             load_use;
   logic             redirect;

   always_comb begin
      load_use = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

      state_d      = state_q;
      fcnt_d       = fcnt_q;
      redirect     = 1'b0;
      PCWrite      = 1'b1;
      PCSrc        = 2'b00;
      IF_ID_Write  = 1'b1;
      Instr_Flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_stall = 1'b0;

      if (!reset_n) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         Instr_Flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (dmem_busy) begin
         // EX is held, so any redirect re-presents once the freeze lifts
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ex_mem_stall = 1'b1;
      end else if (ex_branch_taken || ex_jump) begin
         redirect     = 1'b1;
         PCSrc        = ex_jump ? 2'b10 : 2'b01;
         Instr_Flush  = 1'b1;
         id_ex_bubble = 1'b1;
         fcnt_d       = FLUSH_INIT;
         state_d      = (FLUSH_CYCLES != 0) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
         PCWrite     = imem_ready;
         Instr_Flush = 1'b1;
         if (imem_ready) begin
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q == 3'd1) state_d = RUN;
         end
      end else if (load_use) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (!imem_ready) begin
         PCWrite     = 1'b0;
         Instr_Flush = 1'b1;
      end

      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (perf_clear) begin
         stall_count_d = '0;
         flush_count_d = '0;
      end else begin
         if (!PCWrite) stall_count_d = stall_count_q + CNT_W'(1);
         if (redirect) flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         fcnt_q        <= '0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         fcnt_q        <= fcnt_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_flow_controller.sv
// Directed scoreboard bench: two controllers (FLUSH_CYCLES=1/CNT_W=4 and
// FLUSH_CYCLES=2/CNT_W=32) driven by the same stimulus.
module tb_hazard_flow_controller;

   logic clk = 1'b0;
   logic reset_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_jump;
   logic imem_ready, dmem_busy, perf_clear;

   logic        pcw1, ifid1, fl1, bub1, stl1;
   logic [1:0]  src1;
   logic [3:0]  scnt1, fcnt1;
   logic        pcw2, ifid2, fl2, bub2, stl2;
   logic [1:0]  src2;
   logic [31:0] scnt2, fcnt2;

   // {PCWrite, PCSrc, IF_ID_Write, Instr_Flush, id_ex_bubble, ex_mem_stall}
   localparam logic [6:0] RST  = 7'b0000110;
   localparam logic [6:0] NORM = 7'b1001000;
   localparam logic [6:0] LU   = 7'b0000010;
   localparam logic [6:0] BR   = 7'b1011110;
   localparam logic [6:0] JMP  = 7'b1101110;
   localparam logic [6:0] FRDY = 7'b1001100;
   localparam logic [6:0] WAIT = 7'b0001100;
   localparam logic [6:0] FRZ  = 7'b0000001;

   typedef struct {
      string       tag;
      int unsigned which;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_flow_controller #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
      .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy), .perf_clear(perf_clear),
      .PCWrite(pcw1), .PCSrc(src1), .IF_ID_Write(ifid1), .Instr_Flush(fl1),
      .id_ex_bubble(bub1), .ex_mem_stall(stl1), .stall_count(scnt1), .flush_count(fcnt1));

   hazard_flow_controller #(.FLUSH_CYCLES(2), .CNT_W(32)) u2 (
      .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy), .perf_clear(perf_clear),
      .PCWrite(pcw2), .PCSrc(src2), .IF_ID_Write(ifid2), .Instr_Flush(fl2),
      .id_ex_bubble(bub2), .ex_mem_stall(stl2), .stall_count(scnt2), .flush_count(fcnt2));

   function automatic logic [31:0] observe(input int unsigned which);
      case (which)
         0:       return {25'd0, pcw1, src1, ifid1, fl1, bub1, stl1};
         1:       return {25'd0, pcw2, src2, ifid2, fl2, bub2, stl2};
         2:       return {28'd0, scnt1};
         3:       return {28'd0, fcnt1};
         4:       return scnt2;
         default: return fcnt2;
      endcase
   endfunction

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() != 0) begin
         e   = sb.pop_front();
         obs = observe(e.which);
         n_assert++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %h expected %h", e.tag, e.which, obs, e.val);
         end
      end
   endtask

   task automatic exp_ctrl(input string tag, input logic [6:0] e1, input logic [6:0] e2);
      sb.push_back('{tag, 0, {25'd0, e1}});
      sb.push_back('{tag, 1, {25'd0, e2}});
   endtask

   task automatic step(input string tag, input logic [6:0] e1, input logic [6:0] e2);
      exp_ctrl(tag, e1, e2);
      #1;
      drain();
   endtask

   task automatic cnt(input string tag, input logic [3:0] s1, input logic [3:0] f1,
                      input logic [31:0] s2, input logic [31:0] f2);
      sb.push_back('{tag, 2, {28'd0, s1}});
      sb.push_back('{tag, 3, {28'd0, f1}});
      sb.push_back('{tag, 4, s2});
      sb.push_back('{tag, 5, f2});
      drain();
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_jump = 1'b0;
      imem_ready = 1'b1; dmem_busy = 1'b0; perf_clear = 1'b0;
   endtask

   task automatic next();
      @(negedge clk);
      idle();
   endtask

   initial begin
      reset_n = 1'b0;
      idle();

      // reset values and idle run
      next(); step("reset", RST, RST); cnt("reset_cnt", 0, 0, 0, 0);
      next(); reset_n = 1'b1; step("first_run", NORM, NORM);
      for (int i = 0; i < 9; i++) begin next(); step("run", NORM, NORM); end
      next(); step("run", NORM, NORM); cnt("run_cnt", 0, 0, 0, 0);

      // load-use
      next(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      step("lu_rs2", LU, LU);
      next(); step("lu_clear", NORM, NORM); cnt("lu_cnt", 1, 0, 1, 0);
      next(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
      step("lu_x0", NORM, NORM);
      next(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      imem_ready = 1'b0;
      step("lu_over_imem", LU, LU);
      next(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
      step("lu_unused_rs1", NORM, NORM); cnt("lu_cnt2", 2, 0, 2, 0);
      next(); ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
      step("no_load", NORM, NORM);

      // redirects and flush windows
      next(); perf_clear = 1'b1; step("clear", NORM, NORM);
      next(); ex_branch_taken = 1'b1; step("branch", BR, BR); cnt("clr_cnt", 0, 0, 0, 0);
      next(); step("flush1", FRDY, FRDY);
      next(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      step("lu_in_flush", LU, FRDY);
      next(); step("post_br", NORM, NORM); cnt("br_cnt", 1, 1, 0, 1);
      next(); ex_jump = 1'b1; ex_branch_taken = 1'b1; step("jump_wins", JMP, JMP);
      next(); imem_ready = 1'b0; step("flush_wait1", WAIT, WAIT);
      next(); imem_ready = 1'b0; step("flush_wait2", WAIT, WAIT);
      next(); step("flush_rdy1", FRDY, FRDY);
      next(); step("flush_rdy2", NORM, FRDY);
      next(); step("post_jmp", NORM, NORM); cnt("jmp_cnt", 3, 2, 2, 2);
      next(); ex_branch_taken = 1'b1; step("br_a", BR, BR);
      next(); ex_branch_taken = 1'b1; step("br_reload", BR, BR);
      next(); step("reload1", FRDY, FRDY);
      next(); step("reload2", NORM, FRDY);
      next(); step("post_reload", NORM, NORM); cnt("reload_cnt", 3, 4, 2, 4);

      // freeze holds off a pending redirect
      next(); perf_clear = 1'b1; step("clear2", NORM, NORM);
      next(); dmem_busy = 1'b1; ex_branch_taken = 1'b1; step("freeze1", FRZ, FRZ);
      cnt("clr2_cnt", 0, 0, 0, 0);
      next(); dmem_busy = 1'b1; ex_branch_taken = 1'b1; step("freeze2", FRZ, FRZ);
      next(); dmem_busy = 1'b1; ex_branch_taken = 1'b1; step("freeze3", FRZ, FRZ);
      next(); ex_branch_taken = 1'b1; step("br_after_frz", BR, BR);
      cnt("frz_cnt", 3, 0, 3, 0);
      next(); step("frz_flush1", FRDY, FRDY); cnt("frz_cnt2", 3, 1, 3, 1);
      next(); step("frz_flush2", NORM, FRDY);
      next(); step("frz_done", NORM, NORM);

      // asynchronous reset in the middle of a flush window
      next(); ex_branch_taken = 1'b1; step("br_rst", BR, BR);
      @(posedge clk); #2; reset_n = 1'b0;
      step("async_rst", RST, RST); cnt("async_rst_cnt", 0, 0, 0, 0);
      next(); reset_n = 1'b1; step("rst_abandon", NORM, NORM);

      // counter wrap and clear-over-increment
      for (int i = 0; i < 15; i++) begin
         next(); imem_ready = 1'b0; step("imem_wait", WAIT, WAIT);
      end
      next(); imem_ready = 1'b0; step("imem_wait16", WAIT, WAIT);
      cnt("all_ones", 4'hF, 0, 15, 0);
      next(); imem_ready = 1'b0; perf_clear = 1'b1; step("clr_vs_inc", WAIT, WAIT);
      cnt("wrap", 4'h0, 0, 16, 0);
      next(); step("after_clr", NORM, NORM); cnt("clr_wins", 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
